// File: rtl/cpu_core_seq.sv
// Single-core request sequencer: runs a loadable program of cache reads and writes over a req/ack port
// and writes read data into a local register file. Define CPU_CORE_SEQ_LOOP_EN to repeat the program until reset.
module cpu_core_seq #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int PROG_DEPTH = 8,
    parameter int NREGS      = 8,
    // Derived widths; leave at their defaults.
    parameter int PC_W       = $clog2(PROG_DEPTH),
    parameter int RI_W       = $clog2(NREGS),
    parameter int INSTR_W    = 1 + ADDR_W + RI_W + DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic [PC_W:0]      prog_len,
    input  logic               start,
    output logic [ADDR_W-1:0]  cache_addr,
    output logic               cache_rw,
    output logic               cache_req,
    output logic [DATA_W-1:0]  cache_data_out,
    input  logic               cache_ack,
    input  logic               cache_resp_valid,
    input  logic [DATA_W-1:0]  cache_resp_data,
    output logic               busy,
    output logic               done,
    output logic [PC_W:0]      pc,
    input  logic [RI_W-1:0]    dbg_ridx,
    output logic [DATA_W-1:0]  dbg_rdata
);

    localparam int PCL_W = PC_W + 1;
    localparam logic [PC_W:0] DEPTH_L = PCL_W'(PROG_DEPTH);
    localparam logic [PC_W:0] PC_ONE  = PCL_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RESP,
        S_HALT
    } state_e;

    state_e              state_q, state_d;
    logic [PC_W:0]       pc_q, pc_d, len_q, len_d;
    logic [PC_W:0]       len_clamped, pc_inc;
    logic                req_q, req_d, rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                advance, reg_we, prog_en;

    logic [INSTR_W-1:0]  prog_mem [PROG_DEPTH];
    logic [DATA_W-1:0]   regs_q   [NREGS];

    logic [INSTR_W-1:0]  cur_instr;
    logic                cur_rw;
    logic [ADDR_W-1:0]   cur_addr;
    logic [RI_W-1:0]     cur_rd;
    logic [DATA_W-1:0]   cur_wdata;

    // pc never exceeds len-1 while an instruction is live, so the low bits index the program.
    assign cur_instr = prog_mem[pc_q[PC_W-1:0]];
    assign cur_rw    = cur_instr[INSTR_W-1];
    assign cur_addr  = cur_instr[INSTR_W-2 -: ADDR_W];
    assign cur_rd    = cur_instr[DATA_W +: RI_W];
    assign cur_wdata = cur_instr[DATA_W-1:0];

    assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign pc_inc      = pc_q + PC_ONE;
    assign prog_en     = prog_we && ((state_q == S_IDLE) || (state_q == S_HALT));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        req_d   = req_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        advance = 1'b0;
        reg_we  = 1'b0;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    len_d = len_clamped;
                    pc_d  = '0;
                    if (len_clamped == '0) begin
                        state_d = S_HALT;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // First cycle in ISSUE loads the request registers; the request then holds until ack.
                if (!req_q) begin
                    req_d   = 1'b1;
                    rw_d    = cur_rw;
                    addr_d  = cur_addr;
                    wdata_d = cur_wdata;
                end else if (cache_ack) begin
                    req_d = 1'b0;
                    if (rw_q) advance = 1'b1;
                    else      state_d = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (cache_resp_valid) begin
                    reg_we  = 1'b1;
                    advance = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (pc_inc == len_q) begin
`ifdef CPU_CORE_SEQ_LOOP_EN
                pc_d    = '0;
                state_d = S_ISSUE;
`else
                pc_d    = pc_inc;
                state_d = S_HALT;
                done_d  = 1'b1;
`endif
            end else begin
                pc_d    = pc_inc;
                state_d = S_ISSUE;
            end
        end

        busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT_RESP);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            req_q   <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            req_q   <= req_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (reg_we) regs_q[cur_rd] <= cache_resp_data;
        end
    end

    // NOTE: program memory is deliberately left out of reset; a program loaded before reset survives it.
    always_ff @(posedge clk) begin
        if (prog_en) prog_mem[prog_addr] <= prog_data;
    end

    assign cache_req      = req_q;
    assign cache_rw       = rw_q;
    assign cache_addr     = addr_q;
    assign cache_data_out = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pc             = pc_q;
    assign dbg_rdata      = regs_q[dbg_ridx];

endmodule

// File: tb/tb_cpu_core_seq.sv
// Directed testbench for cpu_core_seq; the loop-mode scenario is selected with CPU_CORE_SEQ_LOOP_EN.
`timescale 1ns/1ps
module tb_cpu_core_seq;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int PC_W    = 3;
    localparam int RI_W    = 3;
    localparam int INSTR_W = 1 + ADDR_W + RI_W + DATA_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               prog_we;
    logic [PC_W-1:0]    prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic [PC_W:0]      prog_len;
    logic               start;
    logic [ADDR_W-1:0]  cache_addr;
    logic               cache_rw;
    logic               cache_req;
    logic [DATA_W-1:0]  cache_data_out;
    logic               cache_ack;
    logic               cache_resp_valid;
    logic [DATA_W-1:0]  cache_resp_data;
    logic               busy;
    logic               done;
    logic [PC_W:0]      pc;
    logic [RI_W-1:0]    dbg_ridx;
    logic [DATA_W-1:0]  dbg_rdata;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] exp_regs [8];

    cpu_core_seq dut (
        .clk              (clk),
        .reset            (reset),
        .prog_we          (prog_we),
        .prog_addr        (prog_addr),
        .prog_data        (prog_data),
        .prog_len         (prog_len),
        .start            (start),
        .cache_addr       (cache_addr),
        .cache_rw         (cache_rw),
        .cache_req        (cache_req),
        .cache_data_out   (cache_data_out),
        .cache_ack        (cache_ack),
        .cache_resp_valid (cache_resp_valid),
        .cache_resp_data  (cache_resp_data),
        .busy             (busy),
        .done             (done),
        .pc               (pc),
        .dbg_ridx         (dbg_ridx),
        .dbg_rdata        (dbg_rdata)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [INSTR_W-1:0] mk_instr(input logic rw, input logic [ADDR_W-1:0] addr,
                                                    input logic [RI_W-1:0] rd, input logic [DATA_W-1:0] wd);
        return {rw, addr, rd, wd};
    endfunction

    task automatic load(input int idx, input logic [INSTR_W-1:0] instr);
        prog_we   = 1'b1;
        prog_addr = PC_W'(idx);
        prog_data = instr;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic kick(input int len);
        prog_len = (PC_W+1)'(len);
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && !cache_req; i++) step();
        check(tag, 64'(cache_req), 64'd1);
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_ridx = RI_W'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), 64'(dbg_rdata), 64'(exp_regs[i]));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) exp_regs[i] = '0;
    endtask

    initial begin
        int hs;
        logic saw_done;
        logic [ADDR_W-1:0] last_addr;
        logic [ADDR_W-1:0] loop_addrs [4];

        reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0; start = 1'b0;
        cache_ack = 1'b0; cache_resp_valid = 1'b0; cache_resp_data = '0; dbg_ridx = '0;
        do_reset();

        check("rst_req",  64'(cache_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pc",   64'(pc), 64'd0);
        check("rst_addr", 64'(cache_addr), 64'd0);
        check("rst_data", 64'(cache_data_out), 64'd0);

`ifndef CPU_CORE_SEQ_LOOP_EN
        // Write then read back through the register file.
        load(0, mk_instr(1'b1, 32'h1000, 3'd0, 32'h1234_5678));
        load(1, mk_instr(1'b0, 32'h1000, 3'd3, 32'h0));
        kick(2);
        check("t1_busy_entry", 64'(busy), 64'd1);
        check("t1_req_entry",  64'(cache_req), 64'd0);
        wait_req("t1_req_w");
        check("t1_addr_w", 64'(cache_addr), 64'h1000);
        check("t1_rw_w",   64'(cache_rw), 64'd1);
        check("t1_data_w", 64'(cache_data_out), 64'h1234_5678);
        cache_ack = 1'b1; step(); cache_ack = 1'b0;
        check("t1_gap_req", 64'(cache_req), 64'd0);
        check("t1_pc1",     64'(pc), 64'd1);
        step();
        check("t1_req_r",  64'(cache_req), 64'd1);
        check("t1_addr_r", 64'(cache_addr), 64'h1000);
        check("t1_rw_r",   64'(cache_rw), 64'd0);
        cache_ack = 1'b1; step(); cache_ack = 1'b0;
        check("t1_wait_busy", 64'(busy), 64'd1);
        check("t1_wait_req",  64'(cache_req), 64'd0);
        step();
        cache_resp_valid = 1'b1; cache_resp_data = 32'h1234_5678;
        step();
        cache_resp_valid = 1'b0;
        exp_regs[3] = 32'h1234_5678;
        check("t1_done", 64'(done), 64'd1);
        check("t1_pc2",  64'(pc), 64'd2);
        check("t1_busy_halt", 64'(busy), 64'd0);
        check_all_regs("t1");
        step();
        check("t1_done_pulse", 64'(done), 64'd0);

        // Request must stay stable while ack is withheld.
        load(0, mk_instr(1'b1, 32'h1004, 3'd0, 32'hABCD_EF12));
        kick(1);
        wait_req("t2_req");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_req_%0d", i),  64'(cache_req), 64'd1);
            check($sformatf("t2_addr_%0d", i), 64'(cache_addr), 64'h1004);
            check($sformatf("t2_data_%0d", i), 64'(cache_data_out), 64'hABCD_EF12);
            step();
        end
        cache_ack = 1'b1; step(); cache_ack = 1'b0;
        check("t2_done", 64'(done), 64'd1);
        check("t2_pc",   64'(pc), 64'd1);
        check("t2_req_drop", 64'(cache_req), 64'd0);
        step();

        // Spurious responses outside WAIT_RESP, including one coincident with the read ack.
        cache_resp_valid = 1'b1; cache_resp_data = 32'hDEAD_BEEF;
        step(); step();
        load(0, mk_instr(1'b0, 32'h2000, 3'd5, 32'h0));
        kick(1);
        wait_req("t4_req");
        cache_ack = 1'b1; step(); cache_ack = 1'b0; cache_resp_valid = 1'b0;
        check("t4_busy_wait", 64'(busy), 64'd1);
        check_all_regs("t4_spurious");
        step();
        check("t4_still_wait", 64'(busy), 64'd1);
        check("t4_no_done",    64'(done), 64'd0);
        cache_resp_valid = 1'b1; cache_resp_data = 32'h55AA_55AA;
        step();
        cache_resp_valid = 1'b0;
        exp_regs[5] = 32'h55AA_55AA;
        check("t4_done", 64'(done), 64'd1);
        check_all_regs("t4_final");

        // prog_len above the program depth runs exactly PROG_DEPTH entries.
        for (int i = 0; i < 8; i++) load(i, mk_instr(1'b1, 32'h4000 + 32'(i * 16), 3'd0, 32'(i)));
        kick(15);
        hs = 0; saw_done = 1'b0; last_addr = '0;
        for (int i = 0; i < 200 && !saw_done; i++) begin
            cache_ack = cache_req;
            if (cache_req) begin
                hs++;
                last_addr = cache_addr;
            end
            step();
            saw_done = done;
        end
        cache_ack = 1'b0;
        check("clamp_done", 64'(saw_done), 64'd1);
        check("clamp_hs",   64'(hs), 64'd8);
        check("clamp_pc",   64'(pc), 64'd8);
        check("clamp_last", 64'(last_addr), 64'h4070);
`else
        // Loop mode: program repeats, done never pulses.
        load(0, mk_instr(1'b1, 32'h1000, 3'd0, 32'h1111_1111));
        load(1, mk_instr(1'b1, 32'h2000, 3'd0, 32'h2222_2222));
        kick(2);
        hs = 0; saw_done = 1'b0;
        for (int i = 0; i < 200 && hs < 4; i++) begin
            cache_ack = cache_req;
            if (cache_req) begin
                loop_addrs[hs] = cache_addr;
                hs++;
            end
            step();
            if (done) saw_done = 1'b1;
        end
        cache_ack = 1'b0;
        check("loop_hs",    64'(hs), 64'd4);
        check("loop_a0",    64'(loop_addrs[0]), 64'h1000);
        check("loop_a1",    64'(loop_addrs[1]), 64'h2000);
        check("loop_a2",    64'(loop_addrs[2]), 64'h1000);
        check("loop_a3",    64'(loop_addrs[3]), 64'h2000);
        check("loop_done",  64'(saw_done), 64'd0);
        check("loop_busy",  64'(busy), 64'd1);
        do_reset();
        check("loop_rst_busy", 64'(busy), 64'd0);
`endif

        // Empty program halts immediately without a request.
        kick(0);
        check("t3_done", 64'(done), 64'd1);
        check("t3_req",  64'(cache_req), 64'd0);
        check("t3_busy", 64'(busy), 64'd0);
        check("t3_pc",   64'(pc), 64'd0);
        step();
        check("t3_done_pulse", 64'(done), 64'd0);
        check("t3_req_after",  64'(cache_req), 64'd0);

        // Reset while waiting for a read response.
        load(0, mk_instr(1'b0, 32'h3000, 3'd5, 32'h0));
        kick(1);
        wait_req("t5_req");
        cache_ack = 1'b1; step(); cache_ack = 1'b0;
        check("t5_busy_wait", 64'(busy), 64'd1);
        do_reset();
        check("t5_req",  64'(cache_req), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_pc",   64'(pc), 64'd0);
        check_all_regs("t5");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
